// File: rtl/dynamixel_servo_responder.sv
// Dynamixel responder: parses instruction packets from rxd, runs PING/READ/WRITE on a byte
// register file and answers with a status packet on txd, driving uart_dir while it talks.
module dynamixel_servo_responder #(
    parameter int CLKS_PER_BIT = 868,
    parameter int REG_DEPTH    = 64,
    parameter int MAX_PARAMS   = 6,
    parameter int RETURN_DELAY = 1000,
    parameter int TIMEOUT_CLKS = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic [7:0] servo_id,
    output logic       txd,
    output logic       uart_dir,
    output logic       busy,
    output logic       reg_wr_valid,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data
);
    localparam int          AW        = $clog2(REG_DEPTH);
    localparam int          PW        = $clog2(MAX_PARAMS);
    localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] HALF_LAST = 32'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] DLY_LAST  = 32'(RETURN_DELAY - 1);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CLKS);
    localparam logic [7:0]  LEN_MAX   = 8'(MAX_PARAMS + 2);
    localparam logic [8:0]  DEPTH9    = 9'(REG_DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {P_IDLE, P_HDR2, P_ID, P_LEN, P_INSTR, P_PARAM, P_CHK,
                              P_EXEC, P_WRITE, P_DELAY, P_TX} p_state_t;

    rx_state_t   rx_st;
    p_state_t    st;
    logic        rx_s1, rx_s2, rx_prev, rx_vld, rx_ferr, rx_en;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;

    logic [7:0]  regs [REG_DEPTH];
    logic [7:0]  params [MAX_PARAMS];
    logic [7:0]  pkt_id, pkt_len, pkt_instr, pcnt, sum, wr_idx;
    logic        chk_ok;
    logic [31:0] tmo, cnt;
    logic [3:0]  tx_idx, tx_bit, tx_total;
    logic [7:0]  stat_id, stat_err, stat_chk, tx_byte;
    logic [2:0]  stat_n;
    logic [7:0]  stat_rd [4];

    logic [7:0]  ex_err, ex_sum, wr_n, wr_addr;
    logic [2:0]  ex_n;
    logic        ex_write, bcast, rx_phase;
    logic [8:0]  rd_end, wr_end;
    logic [7:0]  ex_rd [4];

    // Half duplex: the receiver is held idle while a packet is executed or answered.
    assign rx_en    = (st != P_EXEC) && (st != P_WRITE) && (st != P_DELAY) && (st != P_TX);
    assign rx_phase = st inside {P_HDR2, P_ID, P_LEN, P_INSTR, P_PARAM, P_CHK};
    assign bcast    = (pkt_id == 8'hFE);
    assign wr_addr  = params[0] + wr_idx;
    assign tx_total = 4'd6 + {1'b0, stat_n};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
            rx_st <= RX_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
            rx_vld <= 1'b0; rx_ferr <= 1'b0;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
            if (!rx_en) begin
                rx_st <= RX_IDLE;
            end else begin
                case (rx_st)
                    RX_IDLE: if (rx_prev && !rx_s2) begin
                        rx_cnt <= '0;
                        rx_st  <= RX_START;
                    end
                    RX_START: if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_st  <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else rx_cnt <= rx_cnt + 32'd1;
                    RX_DATA: if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_st <= RX_STOP;
                        else rx_bit <= rx_bit + 3'd1;
                    end else rx_cnt <= rx_cnt + 32'd1;
                    RX_STOP: if (rx_cnt == BIT_LAST) begin
                        rx_vld  <= rx_s2;
                        rx_ferr <= !rx_s2;
                        rx_st   <= RX_IDLE;
                    end else rx_cnt <= rx_cnt + 32'd1;
                    default: rx_st <= RX_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        ex_err   = 8'h00;
        ex_n     = 3'd0;
        ex_write = 1'b0;
        wr_n     = pkt_len - 8'd3;
        rd_end   = {1'b0, params[0]} + {1'b0, params[1]};
        wr_end   = {1'b0, params[0]} + {1'b0, wr_n};
        if (!chk_ok) ex_err = 8'h10;
        else begin
            case (pkt_instr)
                8'h01: ex_err = 8'h00;
                8'h02: if (pkt_len != 8'd4 || params[1] == 8'd0 || params[1] > 8'd4 || rd_end > DEPTH9)
                           ex_err = 8'h08;
                       else ex_n = params[1][2:0];
                8'h03: if (pkt_len < 8'd3 || wr_end > DEPTH9) ex_err = 8'h08;
                       else ex_write = (pkt_len > 8'd3);
                default: ex_err = 8'h40;
            endcase
        end
        ex_sum = servo_id + {5'd0, ex_n} + 8'd2 + ex_err;
        for (int i = 0; i < 4; i++) begin
            ex_rd[i] = regs[AW'(params[0] + 8'(i))];
            if (3'(i) < ex_n) ex_sum = ex_sum + ex_rd[i];
        end
    end

    always_comb begin
        tx_byte = 8'hFF;
        if (tx_idx == 4'd2) tx_byte = stat_id;
        else if (tx_idx == 4'd3) tx_byte = {5'd0, stat_n} + 8'd2;
        else if (tx_idx == 4'd4) tx_byte = stat_err;
        else if (tx_idx == tx_total - 4'd1) tx_byte = stat_chk;
        else if (tx_idx > 4'd4) tx_byte = stat_rd[2'(tx_idx - 4'd5)];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= P_IDLE; busy <= 1'b0; txd <= 1'b1; uart_dir <= 1'b0;
            reg_wr_valid <= 1'b0; reg_wr_addr <= '0; reg_wr_data <= '0;
            pkt_id <= '0; pkt_len <= '0; pkt_instr <= '0; pcnt <= '0; sum <= '0;
            chk_ok <= 1'b0; tmo <= '0; cnt <= '0; wr_idx <= '0; tx_idx <= '0; tx_bit <= '0;
            stat_id <= '0; stat_err <= '0; stat_chk <= '0; stat_n <= '0;
            for (int i = 0; i < 4; i++) stat_rd[i] <= '0;
            for (int i = 0; i < MAX_PARAMS; i++) params[i] <= '0;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            reg_wr_valid <= 1'b0;
            tmo <= (rx_phase && !rx_vld) ? tmo + 32'd1 : '0;
            if (rx_phase && (rx_ferr || tmo == TMO_LIMIT)) begin
                st   <= P_IDLE;
                busy <= 1'b0;
            end else begin
                case (st)
                    P_IDLE: if (rx_vld && rx_sh == 8'hFF) begin
                        st   <= P_HDR2;
                        busy <= 1'b1;
                    end
                    P_HDR2: if (rx_vld) begin
                        if (rx_sh == 8'hFF) st <= P_ID;
                        else begin st <= P_IDLE; busy <= 1'b0; end
                    end
                    P_ID: if (rx_vld && rx_sh != 8'hFF) begin
                        pkt_id <= rx_sh;
                        sum    <= rx_sh;
                        st     <= P_LEN;
                    end
                    P_LEN: if (rx_vld) begin
                        if (rx_sh < 8'd2 || rx_sh > LEN_MAX) begin
                            st <= P_IDLE; busy <= 1'b0;
                        end else begin
                            pkt_len <= rx_sh; sum <= sum + rx_sh; st <= P_INSTR;
                        end
                    end
                    P_INSTR: if (rx_vld) begin
                        pkt_instr <= rx_sh;
                        sum       <= sum + rx_sh;
                        pcnt      <= '0;
                        st        <= (pkt_len == 8'd2) ? P_CHK : P_PARAM;
                    end
                    P_PARAM: if (rx_vld) begin
                        params[PW'(pcnt)] <= rx_sh;
                        sum  <= sum + rx_sh;
                        pcnt <= pcnt + 8'd1;
                        if (pcnt == pkt_len - 8'd3) st <= P_CHK;
                    end
                    P_CHK: if (rx_vld) begin
                        // Packets for other servos are consumed silently.
                        if (pkt_id != servo_id && !bcast) begin
                            st <= P_IDLE; busy <= 1'b0;
                        end else begin
                            chk_ok <= (sum + rx_sh == 8'hFF); st <= P_EXEC;
                        end
                    end
                    P_EXEC: begin
                        stat_id  <= servo_id;
                        stat_err <= ex_err;
                        stat_n   <= ex_n;
                        stat_chk <= ~ex_sum;
                        for (int i = 0; i < 4; i++) stat_rd[i] <= ex_rd[i];
                        wr_idx <= '0;
                        cnt    <= '0;
                        if (ex_write) st <= P_WRITE;
                        else if (bcast) begin st <= P_IDLE; busy <= 1'b0; end
                        else st <= P_DELAY;
                    end
                    P_WRITE: begin
                        regs[AW'(wr_addr)] <= params[PW'(wr_idx + 8'd1)];
                        reg_wr_valid <= 1'b1;
                        reg_wr_addr  <= wr_addr;
                        reg_wr_data  <= params[PW'(wr_idx + 8'd1)];
                        wr_idx       <= wr_idx + 8'd1;
                        if (wr_idx == pkt_len - 8'd4) begin
                            if (bcast) begin st <= P_IDLE; busy <= 1'b0; end
                            else st <= P_DELAY;
                        end
                    end
                    P_DELAY: if (cnt == DLY_LAST) begin
                        cnt <= '0; tx_idx <= '0; tx_bit <= '0;
                        txd <= 1'b0; uart_dir <= 1'b1; st <= P_TX;
                    end else cnt <= cnt + 32'd1;
                    P_TX: if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            if (tx_idx == tx_total - 4'd1) begin
                                txd <= 1'b1; uart_dir <= 1'b0; busy <= 1'b0; st <= P_IDLE;
                            end else begin
                                tx_idx <= tx_idx + 4'd1; tx_bit <= '0; txd <= 1'b0;
                            end
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            txd    <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
                        end
                    end else cnt <= cnt + 32'd1;
                    default: begin st <= P_IDLE; busy <= 1'b0; end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dynamixel_servo_responder.sv
// Directed bench for dynamixel_servo_responder: a vector table of packets and expected status
// replies, plus hand-written sequences for framing error, inter-byte timeout and reset mid-reply.
module tb_dynamixel_servo_responder;
    localparam int CPB = 16;
    localparam int RET = 40;
    localparam int TMO = 600;

    logic       clk = 1'b0;
    logic       rst, rxd;
    logic [7:0] servo_id;
    logic       txd, uart_dir, busy, reg_wr_valid;
    logic [7:0] reg_wr_addr, reg_wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dir_total = 0;
    logic [7:0] tx_q[$];
    typedef struct { logic [7:0] a; logic [7:0] d; int c; } wr_t;
    wr_t wr_q[$];

    typedef struct {
        logic [95:0] pkt; int pkt_n;
        logic [95:0] rsp; int rsp_n;
        int wr_n; logic [7:0] wr_a; logic [7:0] wr_d0; logic [7:0] wr_d1;
    } vec_t;
    vec_t vecs [12];

    dynamixel_servo_responder #(
        .CLKS_PER_BIT(CPB), .REG_DEPTH(64), .MAX_PARAMS(6),
        .RETURN_DELAY(RET), .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk), .reset(rst), .rxd(rxd), .servo_id(servo_id),
        .txd(txd), .uart_dir(uart_dir), .busy(busy),
        .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (uart_dir === 1'b1) dir_total = dir_total + 1;
        if (reg_wr_valid === 1'b1) wr_q.push_back('{reg_wr_addr, reg_wr_data, cyc});
    end

    // Serial receiver for the status bytes, sampling mid-bit.
    initial begin
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = txd;
                end
                repeat (CPB) @(negedge clk);
                tx_q.push_back(b);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (stop ? 2 : CPB) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [95:0] p, input int n);
        for (int i = 0; i < n; i++) send_byte(p[(n - 1 - i) * 8 +: 8], 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({tag, " busy_released"}, {31'd0, busy}, 32'd0);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic check_rsp(input string tag, input int base, input int dbase,
                             input logic [95:0] rsp, input int n);
        logic [31:0] got;
        check({tag, " rsp_len"}, tx_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            got = (base + i < tx_q.size()) ? {24'd0, tx_q[base + i]} : 32'hDEAD;
            check($sformatf("%s rsp[%0d]", tag, i), got, {24'd0, rsp[(n - 1 - i) * 8 +: 8]});
        end
        check({tag, " dir_clks"}, dir_total - dbase, n * 10 * CPB);
    endtask

    initial begin
        int base, dbase, wbase, t;
        string tag;
        vecs[0]  = '{96'hFFFF010201FB,         6, 96'hFFFF010200FC,           6,  0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{96'hFFFF0105031E0002D6,   9, 96'hFFFF010200FC,           6,  2, 8'h1E, 8'h00, 8'h02};
        vecs[2]  = '{96'hFFFF0104021E02D8,     8, 96'hFFFF0104000002F8,       8,  0, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{96'hFFFF01020100,         6, 96'hFFFF010210EC,           6,  0, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{96'hFFFF0104023F02B7,     8, 96'hFFFF010208F4,           6,  0, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{96'hFFFF010207F5,         6, 96'hFFFF010240BC,           6,  0, 8'h00, 8'h00, 8'h00};
        vecs[6]  = '{96'hFFFFFE0403205585,     8, 96'h0,                      0,  1, 8'h20, 8'h55, 8'h00};
        vecs[7]  = '{96'hFFFF0104022001D7,     8, 96'hFFFF01030055A6,         7,  0, 8'h00, 8'h00, 8'h00};
        vecs[8]  = '{96'hFFFF02040321775E,     8, 96'h0,                      0,  0, 8'h00, 8'h00, 8'h00};
        vecs[9]  = '{96'hFFFF0104022101D6,     8, 96'hFFFF01030000FB,         7,  0, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{96'hFFFF0104023C04B8,     8, 96'hFFFF01060000000000F8,  10,  0, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{96'hFFFF0105033FAABB52,   9, 96'hFFFF010208F4,           6,  0, 8'h00, 8'h00, 8'h00};

        rst = 1'b1; rxd = 1'b1; servo_id = 8'h01;
        repeat (3) @(negedge clk);
        check("reset txd", {31'd0, txd}, 32'd1);
        check("reset uart_dir", {31'd0, uart_dir}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset reg_wr_valid", {31'd0, reg_wr_valid}, 32'd0);
        check("reset reg_wr_addr", {24'd0, reg_wr_addr}, 32'd0);
        check("reset reg_wr_data", {24'd0, reg_wr_data}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            tag = $sformatf("vec%0d", v);
            base = tx_q.size(); dbase = dir_total; wbase = wr_q.size();
            send_pkt(vecs[v].pkt, vecs[v].pkt_n);
            wait_idle(tag);
            check_rsp(tag, base, dbase, vecs[v].rsp, vecs[v].rsp_n);
            check({tag, " wr_count"}, wr_q.size() - wbase, vecs[v].wr_n);
            if (vecs[v].wr_n > 0 && wr_q.size() - wbase >= vecs[v].wr_n) begin
                check({tag, " wr0_addr"}, {24'd0, wr_q[wbase].a}, {24'd0, vecs[v].wr_a});
                check({tag, " wr0_data"}, {24'd0, wr_q[wbase].d}, {24'd0, vecs[v].wr_d0});
                if (vecs[v].wr_n > 1) begin
                    check({tag, " wr1_addr"}, {24'd0, wr_q[wbase + 1].a}, {24'd0, vecs[v].wr_a + 8'd1});
                    check({tag, " wr1_data"}, {24'd0, wr_q[wbase + 1].d}, {24'd0, vecs[v].wr_d1});
                    check({tag, " wr_consecutive"}, wr_q[wbase + 1].c - wr_q[wbase].c, 32'd1);
                end
            end
        end

        // Stop bit forced low on the LEN byte: packet must be dropped.
        base = tx_q.size();
        send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0); send_byte(8'h01, 1'b1); send_byte(8'hFB, 1'b1);
        repeat (RET + 20 * CPB) @(negedge clk);
        check("frame busy", {31'd0, busy}, 32'd0);
        check("frame no_rsp", tx_q.size() - base, 32'd0);

        // Stall after INSTR longer than the timeout, then a clean PING.
        send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1); send_byte(8'h01, 1'b1);
        check("tmo busy_before", {31'd0, busy}, 32'd1);
        repeat (TMO + 100) @(negedge clk);
        check("tmo busy_after", {31'd0, busy}, 32'd0);
        base = tx_q.size(); dbase = dir_total;
        send_pkt(96'hFFFF010201FB, 6);
        wait_idle("tmo ping");
        check_rsp("tmo ping", base, dbase, 96'hFFFF010200FC, 6);

        // Reset while the status reply is on the wire.
        send_pkt(96'hFFFF010201FB, 6);
        t = 0;
        while (uart_dir !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("rst dir_seen", {31'd0, uart_dir}, 32'd1);
        repeat (3 * CPB + 3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst txd", {31'd0, txd}, 32'd1);
        check("rst uart_dir", {31'd0, uart_dir}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        base = tx_q.size(); dbase = dir_total;
        send_pkt(96'hFFFF0104021E02D8, 8);
        wait_idle("rst read");
        check_rsp("rst read", base, dbase, 96'hFFFF0104000000FA, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
